// File: rtl/addsub_4bit_if.sv
// Operand/result bundle for addsub_4bit. The ovf signal exists only when
// ADDSUB_OVF_EN is defined.
interface addsub_4bit_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       d;
  logic [3:0] s;
  logic       c_out;
`ifdef ADDSUB_OVF_EN
  logic       ovf;
`endif

`ifdef ADDSUB_OVF_EN
  modport master (output a, output b, output d, input s, input c_out, input ovf);
  modport slave  (input a, input b, input d, output s, output c_out, output ovf);
`else
  modport master (output a, output b, output d, input s, input c_out);
  modport slave  (input a, input b, input d, output s, output c_out);
`endif
endinterface

// File: rtl/addsub_4bit.sv
// 4-bit ripple-carry adder/subtractor: s = b + a when d = 0, s = b - a when d = 1.
// The registered signed-overflow flag is built only when ADDSUB_OVF_EN is defined.
module addsub_4bit (
  input  logic            clk,
  input  logic            rst_n,
  addsub_4bit_if.slave    bus
);

  localparam int unsigned WIDTH = 4;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_c;

  logic [WIDTH-1:0] r_s;
  logic             r_c_out;

  // Carry-in equals d, so d = 1 turns ~a into -a (two's complement).
  assign w_c[0] = bus.d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_x[i]   = bus.a[i] ^ bus.d;
    assign w_sum[i] = bus.b[i] ^ w_x[i] ^ w_c[i];
    assign w_c[i+1] = (bus.b[i] & w_x[i]) | (bus.b[i] & w_c[i]) | (w_x[i] & w_c[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= WIDTH'(0);
      r_c_out <= 1'b0;
    end else begin
      r_s     <= w_sum;
      r_c_out <= w_c[WIDTH];
    end
  end

  assign bus.s     = r_s;
  assign bus.c_out = r_c_out;

`ifdef ADDSUB_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_addsub_4bit.sv
// Directed self-checking bench for addsub_4bit; the ovf checks are compiled
// in when ADDSUB_OVF_EN is defined.
module tb_addsub_4bit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  addsub_4bit_if u_if ();

  addsub_4bit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] es, input logic ec,
                           input logic ev);
    check({tag, ".s"}, 8'(u_if.s), 8'(es));
    check({tag, ".c_out"}, 8'(u_if.c_out), 8'(ec));
`ifdef ADDSUB_OVF_EN
    check({tag, ".ovf"}, 8'(u_if.ovf), 8'(ev));
`else
    if (ev === 1'bx) $display("unexpected x in ovf expectation for %s", tag);
`endif
  endtask

  // Drive at negedge, check just after the next rising edge.
  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic d, input logic [3:0] es, input logic ec,
                       input logic ev);
    @(negedge clk);
    u_if.a = a;
    u_if.b = b;
    u_if.d = d;
    @(posedge clk);
    #1;
    check_out(tag, es, ec, ev);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    u_if.a   = 4'd0;
    u_if.b   = 4'd0;
    u_if.d   = 1'b0;

    // Reset held with random operands and a running clock
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_if.a = 4'($urandom_range(0, 15));
      u_if.b = 4'($urandom_range(0, 15));
      u_if.d = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_out("reset_hold", 4'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply("first", 4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0);

    // Add sweep: a + (15 - a) is always 15 with no carry
    for (int i = 0; i < 16; i++) begin
      apply("add_sweep", 4'(i), 4'(15 - i), 1'b0, 4'd15, 1'b0, 1'b0);
    end
    apply("add_9_8", 4'd9, 4'd8, 1'b0, 4'd1, 1'b1, 1'b1);
    apply("add_15_15", 4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0);

    apply("sub_7_1", 4'd1, 4'd7, 1'b1, 4'd6, 1'b1, 1'b0);
    apply("sub_6_2", 4'd2, 4'd6, 1'b1, 4'd4, 1'b1, 1'b0);
    apply("sub_5_0", 4'd0, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0);
    apply("sub_15_11", 4'd11, 4'd15, 1'b1, 4'd4, 1'b1, 1'b0);
    apply("sub_15_12", 4'd12, 4'd15, 1'b1, 4'd3, 1'b1, 1'b0);
    apply("sub_15_13", 4'd13, 4'd15, 1'b1, 4'd2, 1'b1, 1'b0);
    apply("sub_15_14", 4'd14, 4'd15, 1'b1, 4'd1, 1'b1, 1'b0);
    apply("sub_15_15", 4'd15, 4'd15, 1'b1, 4'd0, 1'b1, 1'b0);
    apply("sub_6_6", 4'd6, 4'd6, 1'b1, 4'd0, 1'b1, 1'b0);
    apply("sub_borrow", 4'd12, 4'd3, 1'b1, 4'd7, 1'b0, 1'b0);

    // Mode toggles every cycle; these also cover the overflow cases
    apply("ovf_add", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);
    apply("ovf_sub", 4'd1, 4'd8, 1'b1, 4'd7, 1'b1, 1'b1);
    apply("no_ovf", 4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);
    apply("sub_zero_a", 4'd0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0);

    // Asynchronous reset between edges while s = 15
    apply("pre_async", 4'd0, 4'd15, 1'b0, 4'd15, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("async_hold", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("after_rst", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
